// File: rtl/range_display_pkg.sv
// Shared types and constants for the range display block: FSM state encoding,
// digit count, special segment patterns and the double-dabble nibble adjust.
package range_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'h00;
    localparam logic [6:0] SEG_DASH   = 7'h40;

    // Add 3 to every BCD nibble that is 5 or more, so the following left
    // shift carries correctly into the next decimal digit.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] value);
        logic [15:0] result;
        result = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (value[4*i +: 4] >= 4'd5) begin
                result[4*i +: 4] = value[4*i +: 4] + 4'd3;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/range_display_bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decode, active-high {g,f,e,d,c,b,a}.
// Codes above 9 decode to a blank digit.
module bcd_to_seg7
    import range_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup of the segment pattern for one decimal digit
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/range_display.sv
// Range display: converts a binary range value to four BCD digits with a
// serial double-dabble engine, then scans the last result onto a multiplexed
// 4-digit 7-segment display with leading-zero blanking and an error dash mode.
module range_display
    import range_display_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int SCAN_DIV = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] range_in,
    input  logic             range_valid,
    input  logic             error_in,
    output logic             busy,
    output logic [15:0]      bcd_out,
    output logic             bcd_valid,
    output logic [6:0]       segments,
    output logic [3:0]       digit_en,
    output logic             error_led
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t             state_reg;
    logic [WIDTH-1:0]   shifter_reg;
    logic [15:0]        scratch_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               err_cap_reg;
    logic [15:0]        bcd_out_reg;
    logic               bcd_valid_reg;
    logic               error_led_reg;

    logic [SCAN_W-1:0]  scan_cnt_reg;
    logic [1:0]         digit_idx_reg;

    logic [3:0]            sel_digit;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] digit_lit;

    // Conversion FSM: capture, shift WIDTH times through the BCD scratch, publish
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            shifter_reg   <= '0;
            scratch_reg   <= '0;
            count_reg     <= '0;
            err_cap_reg   <= 1'b0;
            bcd_out_reg   <= '0;
            bcd_valid_reg <= 1'b0;
            error_led_reg <= 1'b0;
        end else begin
            bcd_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (range_valid) begin
                        shifter_reg <= range_in;
                        err_cap_reg <= error_in;
                        scratch_reg <= '0;
                        count_reg   <= CNT_W'(WIDTH);
                        state_reg   <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    {scratch_reg, shifter_reg} <= {bcd_adjust(scratch_reg), shifter_reg} << 1;
                    count_reg <= count_reg - CNT_W'(1);
                    if (count_reg == CNT_W'(1)) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_out_reg   <= scratch_reg;
                    error_led_reg <= err_cap_reg;
                    bcd_valid_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Free-running scan divider; the digit index steps once per SCAN_DIV cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= 2'd0;
        end else if (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= digit_idx_reg + 2'd1;
        end else begin
            scan_cnt_reg  <= scan_cnt_reg + SCAN_W'(1);
        end
    end

    // A digit is lit when it or any more significant digit is non-zero;
    // digit 0 is always lit so a zero result still shows "0".
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lit
            if (gi == 0) begin : g_lsd
                assign digit_lit[gi] = 1'b1;
            end else begin : g_upper
                assign digit_lit[gi] = |bcd_out_reg[15:4*gi];
            end
        end
    endgenerate

    // Select the nibble of the currently scanned digit
    always_comb begin
        sel_digit = bcd_out_reg[3:0];
        case (digit_idx_reg)
            2'd0: sel_digit = bcd_out_reg[3:0];
            2'd1: sel_digit = bcd_out_reg[7:4];
            2'd2: sel_digit = bcd_out_reg[11:8];
            2'd3: sel_digit = bcd_out_reg[15:12];
            default: sel_digit = bcd_out_reg[3:0];
        endcase
    end

    bcd_to_seg7 u_seg (
        .bcd (sel_digit),
        .seg (seg_raw)
    );

    // Segment output priority: error dash, then blanking, then decoded digit
    always_comb begin
        segments = SEG_BLANK;
        if (error_led_reg) begin
            segments = SEG_DASH;
        end else if (digit_lit[digit_idx_reg]) begin
            segments = seg_raw;
        end
    end

    assign digit_en  = 4'b0001 << digit_idx_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign bcd_out   = bcd_out_reg;
    assign bcd_valid = bcd_valid_reg;
    assign error_led = error_led_reg;

endmodule
